// File: rtl/exe_iter_divider_pkg.sv
// Shared state encoding and constants for the EXE-stage iterative divider.
package exe_iter_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_MAX_W = 64;

  // Quotient magnitude produced by a zero divisor; narrowed to WIDTH by the user.
  localparam logic [DIV_MAX_W-1:0] DIV0_QUOT = '1;

  function automatic logic [DIV_MAX_W-1:0] div0_quot();
    return DIV0_QUOT;
  endfunction

endpackage

// File: rtl/exe_iter_divider_div_step.sv
// One restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module exe_iter_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;

  // The trial compare is WIDTH+1 bits; a kept difference always fits in WIDTH bits.
  assign shifted_s = {i_rem, i_msb};
  assign diff_s    = shifted_s[WIDTH-1:0] - i_divisor;

  // Keep the difference when it is non-negative, otherwise restore.
  always_comb begin
    if (shifted_s >= {1'b0, i_divisor}) begin
      o_qbit = 1'b1;
      o_rem  = diff_s;
    end else begin
      o_qbit = 1'b0;
      o_rem  = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/exe_iter_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU in EXE; stalls the pipe while iterating.
// Optional DIV_FAST_SPECIAL_EN: zero divisor, |dividend|<|divisor| and |divisor|==1 finish in one cycle.
module exe_iter_divider
  import exe_iter_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_advance,
  input  logic             i_cancel,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;

  logic             dvd_neg_s, dsr_neg_s;
  logic [WIDTH-1:0] dvd_abs_s, dsr_abs_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] quot_mag_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Magnitudes are unsigned WIDTH bits, so |0x80000000| needs no extra bit.
  assign dvd_neg_s  = i_signed & i_dividend[WIDTH-1];
  assign dsr_neg_s  = i_signed & i_divisor[WIDTH-1];
  assign dvd_abs_s  = cond_neg(i_dividend, dvd_neg_s);
  assign dsr_abs_s  = cond_neg(i_divisor, dsr_neg_s);
  assign quot_mag_s = {dvd_q[WIDTH-2:0], step_q_s};

  exe_iter_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (rem_q),
    .i_msb     (dvd_q[WIDTH-1]),
    .i_divisor (dsr_q),
    .o_rem     (step_rem_s),
    .o_qbit    (step_q_s)
  );

`ifdef DIV_FAST_SPECIAL_EN
  logic             fast_hit_s;
  logic [WIDTH-1:0] fast_q_s, fast_r_s;

  // Early-out magnitudes; signs are applied on the way into the output flops.
  always_comb begin
    fast_hit_s = 1'b1;
    fast_q_s   = '0;
    fast_r_s   = dvd_abs_s;
    if (dsr_abs_s == '0) begin
      fast_q_s = WIDTH'(div0_quot());
    end else if (dvd_abs_s < dsr_abs_s) begin
      fast_q_s = '0;
    end else if (dsr_abs_s == WIDTH'(1)) begin
      fast_q_s = dvd_abs_s;
      fast_r_s = '0;
    end else begin
      fast_hit_s = 1'b0;
    end
  end
`endif

  // Next-state and datapath; cancel wins over start and advance and leaves results untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = done_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    if (i_cancel) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            dvd_d   = dvd_abs_s;
            dsr_d   = dsr_abs_s;
            rem_d   = '0;
            qneg_d  = dvd_neg_s ^ dsr_neg_s;
            rneg_d  = dvd_neg_s;
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (fast_hit_s) begin
              cnt_d   = '0;
              state_d = ST_DONE;
              done_d  = 1'b1;
              quot_d  = cond_neg(fast_q_s, dvd_neg_s ^ dsr_neg_s);
              remo_d  = cond_neg(fast_r_s, dvd_neg_s);
            end else begin
              done_d  = 1'b0;
            end
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_d = step_rem_s;
          dvd_d = quot_mag_s;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            quot_d  = cond_neg(quot_mag_s, qneg_q);
            remo_d  = cond_neg(step_rem_s, rneg_q);
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_DONE: begin
          // Waiting for advance keeps a stalled EXE from re-issuing the same divide.
          if (i_advance) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign o_stall     = ((state_q == ST_IDLE) && i_start && !i_cancel) || (state_q == ST_CALC);
  assign o_done      = done_q;
  assign o_quotient  = quot_q;
  assign o_remainder = remo_q;

endmodule

// File: tb/tb_exe_iter_divider.sv
// Table-driven plus scoreboard bench for exe_iter_divider, with cancel/reset/hold sequences.
module tb_exe_iter_divider;

  localparam int W = 32;
`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn, i_start, i_signed, i_advance, i_cancel;
  logic [W-1:0] i_dividend, i_divisor;
  logic         o_stall, o_done;
  logic [W-1:0] o_quotient, o_remainder;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  res_t         exp_q[$];
  vec_t         vecs[14];
  logic [W-1:0] last_q, last_r;

  always #5 clk = ~clk;

  exe_iter_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_advance   (i_advance),
    .i_cancel    (i_cancel),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == '0) begin
      m.r = a;
      m.q = (sgn && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.q = 32'h8000_0000;
      m.r = 32'd0;
    end else if (sgn) begin
      m.q = $signed(a) / $signed(b);
      m.r = $signed(a) % $signed(b);
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] am, bm;
    am = (sgn && a[W-1]) ? (~a + 32'd1) : a;
    bm = (sgn && b[W-1]) ? (~b + 32'd1) : b;
    if (FAST_EN && (bm == '0 || am < bm || bm == 32'd1)) return 1;
    return W + 1;
  endfunction

  task automatic do_div(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r,
                        input int hold);
    res_t e;
    int   edges, stalls, lat;
    lat = exp_lat(sgn, a, b);
    @(negedge clk);
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    i_advance  = 1'b0;
    exp_q.push_back('{q: q, r: r});
    #1;
    edges  = 0;
    stalls = 0;
    while (!o_done && edges < 200) begin
      if (o_stall) stalls++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({name, " latency"}, 32'(edges), 32'(lat));
    check({name, " stall_cycles"}, 32'(stalls), 32'(lat));
    check({name, " quotient"}, o_quotient, e.q);
    check({name, " remainder"}, o_remainder, e.r);
    check({name, " stall_in_done"}, 32'(o_stall), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " hold_done"}, 32'(o_done), 32'd1);
      check({name, " hold_no_restart"}, 32'(o_stall), 32'd0);
      check({name, " hold_quotient"}, o_quotient, e.q);
    end
    last_q    = e.q;
    last_r    = e.r;
    i_start   = 1'b0;
    i_advance = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_advance = 1'b0;
    check({name, " back_to_idle"}, 32'({o_done, o_stall}), 32'd0);
  endtask

  initial begin
    res_t m;
    logic [W-1:0] ra, rb;
    logic         rs;
    bit           seen_done;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[10] = '{1'b0, 32'd1000007,    32'd1000,       32'd1000,       32'd7};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};
    vecs[12] = '{1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFF,  32'd9,          32'd0};
    vecs[13] = '{1'b1, 32'd7,          32'd1,          32'd7,          32'd0};

    resetn     = 1'b0;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    i_advance  = 1'b0;
    i_cancel   = 1'b0;
    last_q     = '0;
    last_r     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset done", 32'(o_done), 32'd0);
    check("reset stall", 32'(o_stall), 32'd0);
    check("reset quotient", o_quotient, 32'd0);
    check("reset remainder", o_remainder, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             (i == 0) ? 4 : 0);
    end

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      m  = model(rs, ra, rb);
      do_div($sformatf("rand%0d", i), rs, ra, rb, m.q, m.r, 0);
    end

    // Cancel together with start in IDLE must not launch a divide.
    @(negedge clk);
    i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
    i_start = 1'b1; i_cancel = 1'b1;
    #1;
    check("cancel_idle stall", 32'(o_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0; i_cancel = 1'b0;
    #1;
    check("cancel_idle no_calc", 32'({o_done, o_stall}), 32'd0);

    // Cancel on CALC cycle 10.
    @(negedge clk);
    i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cancel_calc stall_before", 32'(o_stall), 32'd1);
    i_cancel = 1'b1; i_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_cancel = 1'b0;
    check("cancel_calc stall_after", 32'(o_stall), 32'd0);
    check("cancel_calc done", 32'(o_done), 32'd0);
    check("cancel_calc quotient_held", o_quotient, last_q);
    check("cancel_calc remainder_held", o_remainder, last_r);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done = seen_done | o_done;
    end
    check("cancel_calc never_done", 32'(seen_done), 32'd0);

    // Reset pulse mid-CALC; previous results must be cleared.
    do_div("pre_reset", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 0);
    @(negedge clk);
    i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    resetn  = 1'b0;
    #1;
    check("reset_calc done", 32'(o_done), 32'd0);
    check("reset_calc stall", 32'(o_stall), 32'd0);
    check("reset_calc quotient", o_quotient, 32'd0);
    check("reset_calc remainder", o_remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_div("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
